ram_bytelane_ctrl: RTL and testbench

RAM_BYTELANE_CTRL -- requirements
Module: ram_bytelane_ctrl

---
 rtl/ram_bytelane_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ram_bytelane_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bytelane_ctrl.sv
// Byte-addressed, big-endian RAM with a 4-phase enable/done handshake,
// programmable read/write wait states, sized loads with sign extension and alignment faults.
module ram_bytelane_ctrl #(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              readWrite,
  input  logic [1:0]        MAS,
  input  logic              signedLoad,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        dbg_state
);

  // Handshake: the requester raises enable with the request fields stable; they are
  // captured on that edge. done rises once the access has completed and stays high
  // while enable is held. Dropping enable returns the FSM to IDLE on the next edge,
  // lowering done and busy together; only then is a new request accepted.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;
  localparam logic [3:0] RD_CNT   = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT   = 4'(WR_WAIT);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [1:0]          mas_q, mas_d;
  logic                sl_q, sl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         dout_q, dout_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;

  logic [7:0]          mem [DEPTH];

  logic [3:0]          wait_sel;
  logic                acc_err;
  logic [ADDR_W-1:0]   a0, a1, a2, a3;
  logic [7:0]          rb0, rb1, rb2, rb3;
  logic [31:0]         rdata;
  logic [3:0]          lane_we;
  logic [7:0]          wb0, wb1, wb2, wb3;

  assign wait_sel = readWrite ? RD_CNT : WR_CNT;

  assign acc_err = (mas_q == 2'b11)
                 | ((mas_q == MAS_HALF) & addr_q[0])
                 | ((mas_q == MAS_WORD) & (addr_q[1:0] != 2'b00));

  // Lane 0 is the addressed byte and is always the most significant of the unit.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  assign rb0 = mem[a0];
  assign rb1 = mem[a1];
  assign rb2 = mem[a2];
  assign rb3 = mem[a3];

  always_comb begin
    rdata = {rb0, rb1, rb2, rb3};
    case (mas_q)
      MAS_BYTE: rdata = {{24{sl_q & rb0[7]}}, rb0};
      MAS_HALF: rdata = {{16{sl_q & rb0[7]}}, rb0, rb1};
      default:  rdata = {rb0, rb1, rb2, rb3};
    endcase
  end

  always_comb begin
    lane_we = 4'b0000;
    wb0     = wdata_q[31:24];
    wb1     = wdata_q[23:16];
    wb2     = wdata_q[15:8];
    wb3     = wdata_q[7:0];
    if ((state_q == ST_ACCESS) && !rw_q && !acc_err) begin
      case (mas_q)
        MAS_BYTE: begin
          lane_we = 4'b0001;
          wb0     = wdata_q[7:0];
        end
        MAS_HALF: begin
          lane_we = 4'b0011;
          wb0     = wdata_q[15:8];
          wb1     = wdata_q[7:0];
        end
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // Storage is intentionally not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (lane_we[0]) mem[a0] <= wb0;
    if (lane_we[1]) mem[a1] <= wb1;
    if (lane_we[2]) mem[a2] <= wb2;
    if (lane_we[3]) mem[a3] <= wb3;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    mas_d   = mas_q;
    sl_d    = sl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          rw_d    = readWrite;
          mas_d   = MAS;
          sl_d    = signedLoad;
          addr_d  = address;
          wdata_d = dataIn;
          if (wait_sel != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = wait_sel;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        if (rw_q && !acc_err) dout_d = rdata;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // done is raised one cycle after entering DONE, giving wait+2 total latency.
        done_d  = 1'b1;
        fault_d = acc_err;
        if (done_q && !enable) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      mas_q   <= 2'b00;
      sl_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      mas_q   <= mas_d;
      sl_q    <= sl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign dataOut   = dout_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_bytelane_ctrl.sv
// Directed bench for ram_bytelane_ctrl: sized big-endian accesses, sign extension,
// alignment faults, handshake latency, asynchronous reset mid-write and the top boundary.
module tb_ram_bytelane_ctrl;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_WORD = 2'b10;
  localparam logic [1:0] M_ILL  = 2'b11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              readWrite;
  logic [1:0]        MAS;
  logic              signedLoad;
  logic [ADDR_W-1:0] address;
  logic [31:0]       dataIn;
  logic [31:0]       dataOut;
  logic              done;
  logic              busy;
  logic              fault;
  logic [1:0]        dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ram_bytelane_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_WAIT(2), .WR_WAIT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .readWrite(readWrite),
    .MAS(MAS), .signedLoad(signedLoad), .address(address), .dataIn(dataIn),
    .dataOut(dataOut), .done(done), .busy(busy), .fault(fault), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: one full 4-phase transaction, optionally holding enable after done.
  task automatic xfer(input logic rw, input logic [1:0] mas, input logic sl,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] din, input int hold,
                      output int lat, output logic flt, output logic [31:0] dout);
    int cyc;
    cyc = 0;
    @(negedge clk);
    readWrite  = rw;
    MAS        = mas;
    signedLoad = sl;
    address    = addr;
    dataIn     = din;
    enable     = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      address = ~addr;
      dataIn  = ~din;
    end
    check_eq("done_seen", done, 1'b1);
    lat  = cyc - 1;
    flt  = fault;
    dout = dataOut;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check_eq("done_held", done, 1'b1);
      check_eq("state_held", dbg_state, 2'd3);
    end
    enable = 1'b0;
    @(negedge clk);
    check_eq("busy_release", busy, 1'b0);
    check_eq("done_release", done, 1'b0);
  endtask

  task automatic wr(input logic [1:0] mas, input logic [ADDR_W-1:0] addr,
                    input logic [31:0] din, input logic exp_fault);
    int lat;
    logic flt;
    logic [31:0] dout;
    xfer(1'b0, mas, 1'b0, addr, din, 0, lat, flt, dout);
    check_eq("wr_latency", lat, 5);
    check_eq("wr_fault", flt, exp_fault);
  endtask

  task automatic rd(input logic [1:0] mas, input logic sl, input logic [ADDR_W-1:0] addr,
                    input logic [31:0] exp_data, input logic exp_fault);
    int lat;
    logic flt;
    logic [31:0] dout;
    exp_q.push_back(exp_data);
    xfer(1'b1, mas, sl, addr, 32'd0, 0, lat, flt, dout);
    check_eq("rd_latency", lat, 4);
    check_eq("rd_fault", flt, exp_fault);
    check_eq("rd_data", dout, exp_q.pop_front());
  endtask

  initial begin
    int lat;
    logic flt;
    logic [31:0] dout;

    reset_n    = 1'b0;
    enable     = 1'b0;
    readWrite  = 1'b0;
    MAS        = 2'b00;
    signedLoad = 1'b0;
    address    = '0;
    dataIn     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_dataOut", dataOut, 32'd0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    reset_n = 1'b1;

    wr(M_BYTE, 9'h000, 32'h0000005A, 1'b0);
    wr(M_WORD, 9'h010, 32'hDEADBEEF, 1'b0);
    rd(M_WORD, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
    rd(M_BYTE, 1'b0, 9'h011, 32'h000000AD, 1'b0);

    // Byte write lands in the last lane of the word at 0x010: DE AD BE 80
    wr(M_BYTE, 9'h013, 32'hFFFFFF80, 1'b0);
    rd(M_BYTE, 1'b1, 9'h013, 32'hFFFFFF80, 1'b0);
    rd(M_BYTE, 1'b0, 9'h013, 32'h00000080, 1'b0);
    rd(M_HALF, 1'b1, 9'h012, 32'hFFFFBE80, 1'b0);
    rd(M_HALF, 1'b0, 9'h010, 32'h0000DEAD, 1'b0);
    rd(M_HALF, 1'b1, 9'h010, 32'hFFFFDEAD, 1'b0);
    rd(M_WORD, 1'b1, 9'h010, 32'hDEADBE80, 1'b0);

    // Faulting accesses leave memory and dataOut untouched
    wr(M_WORD, 9'h020, 32'h11223344, 1'b0);
    wr(M_WORD, 9'h021, 32'hCAFEF00D, 1'b1);
    rd(M_HALF, 1'b0, 9'h023, 32'hDEADBE80, 1'b1);
    rd(M_ILL,  1'b0, 9'h020, 32'hDEADBE80, 1'b1);
    wr(M_ILL,  9'h020, 32'hFFFFFFFF, 1'b1);
    rd(M_WORD, 1'b0, 9'h020, 32'h11223344, 1'b0);

    // done persists while enable stays high
    xfer(1'b1, M_WORD, 1'b0, 9'h010, 32'd0, 3, lat, flt, dout);
    check_eq("hold_latency", lat, 4);
    check_eq("hold_data", dout, 32'hDEADBE80);

    // Asynchronous reset while a write sits in WAIT
    wr(M_WORD, 9'h040, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    readWrite = 1'b0;
    MAS       = M_WORD;
    address   = 9'h040;
    dataIn    = 32'h12345678;
    enable    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_wait_state", dbg_state, 2'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_dataOut", dataOut, 32'd0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_fault", fault, 1'b0);
    check_eq("arst_state", dbg_state, 2'd0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(M_WORD, 1'b0, 9'h040, 32'hA5A5A5A5, 1'b0);

    // Top-of-memory word and the byte at address 0
    wr(M_WORD, 9'(DEPTH - 4), 32'h0BADF00D, 1'b0);
    rd(M_WORD, 1'b0, 9'(DEPTH - 4), 32'h0BADF00D, 1'b0);
    rd(M_BYTE, 1'b0, 9'h000, 32'h0000005A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
